// File: rtl/nibble_deframer.sv
// Recovers framed payload bytes from a strobed nibble stream (A,5,LEN,payload,CHK)
// and queues them in a 4-deep first-word-fall-through FIFO.
module nibble_deframer #(
  parameter logic [3:0]  PROB_MIN = 4'd8,
  parameter logic [15:0] TIMEOUT  = 16'd20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] info_judge,
  input  logic [3:0] info_prob,
  input  logic       sum_over,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_start,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic       busy
);

  typedef enum logic [2:0] {S_HUNT, S_SYNC2, S_LEN, S_DATA_HI, S_DATA_LO, S_CHK} state_t;

  localparam logic [2:0] ERR_CHK  = 3'd1;
  localparam logic [2:0] ERR_PROB = 3'd2;
  localparam logic [2:0] ERR_TO   = 3'd3;
  localparam logic [2:0] ERR_OVF  = 3'd4;
  localparam logic [2:0] ERR_LEN0 = 3'd5;

  state_t      state, nxt_state;
  logic        sum_over_d, strobe, low_prob;
  logic [3:0]  byte_cnt, nxt_cnt, xor_acc, nxt_xor, hi_nib, nxt_hi;
  logic [2:0]  nxt_code;
  logic        nxt_start, nxt_ok, nxt_err;
  logic [15:0] to_cnt;
  logic        to_hit;

  logic [3:0][7:0] fifo_mem;
  logic [1:0]      wr_ptr, rd_ptr;
  logic [2:0]      fifo_cnt;
  logic            push, pop, full;

  assign strobe   = sum_over_d && !sum_over;
  assign low_prob = info_prob < PROB_MIN;
  assign to_hit   = to_cnt == TIMEOUT;
  assign busy     = state != S_HUNT;

  assign byte_valid = fifo_cnt != 3'd0;
  assign byte_data  = fifo_mem[rd_ptr];
  assign full       = fifo_cnt == 3'd4;
  assign pop        = byte_valid && byte_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sum_over_d <= 1'b0;
    else      sum_over_d <= sum_over;
  end

  // Idle-gap timer; saturates so a stuck count cannot wrap past the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          to_cnt <= '0;
    else if (strobe || state == S_HUNT) to_cnt <= '0;
    else if (!to_hit)                  to_cnt <= to_cnt + 16'd1;
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = byte_cnt;
    nxt_xor   = xor_acc;
    nxt_hi    = hi_nib;
    nxt_code  = err_code;
    nxt_start = 1'b0;
    nxt_ok    = 1'b0;
    nxt_err   = 1'b0;
    push      = 1'b0;
    if (strobe) begin
      case (state)
        S_HUNT: if (!low_prob && info_judge == 4'hA) nxt_state = S_SYNC2;
        S_SYNC2: begin
          if (!low_prob && info_judge == 4'h5) begin
            nxt_state = S_LEN;
            nxt_start = 1'b1;
            nxt_code  = 3'd0;
          end else if (!low_prob && info_judge == 4'hA) begin
            nxt_state = S_SYNC2;
          end else begin
            nxt_state = S_HUNT;
          end
        end
        default: begin
          if (low_prob) begin
            nxt_state = S_HUNT;
            nxt_err   = 1'b1;
            nxt_code  = ERR_PROB;
          end else begin
            case (state)
              S_LEN: begin
                if (info_judge == 4'h0) begin
                  nxt_state = S_HUNT;
                  nxt_err   = 1'b1;
                  nxt_code  = ERR_LEN0;
                end else begin
                  nxt_cnt   = info_judge;
                  nxt_xor   = info_judge;
                  nxt_state = S_DATA_HI;
                end
              end
              S_DATA_HI: begin
                nxt_hi    = info_judge;
                nxt_xor   = xor_acc ^ info_judge;
                nxt_state = S_DATA_LO;
              end
              S_DATA_LO: begin
                nxt_xor = xor_acc ^ info_judge;
                // A simultaneous pop frees the slot, so only a stalled full FIFO drops.
                if (full && !pop) begin
                  nxt_state = S_HUNT;
                  nxt_err   = 1'b1;
                  nxt_code  = ERR_OVF;
                end else begin
                  push      = 1'b1;
                  nxt_cnt   = byte_cnt - 4'd1;
                  nxt_state = (byte_cnt == 4'd1) ? S_CHK : S_DATA_HI;
                end
              end
              S_CHK: begin
                nxt_state = S_HUNT;
                if (info_judge == xor_acc) begin
                  nxt_ok = 1'b1;
                end else begin
                  nxt_err  = 1'b1;
                  nxt_code = ERR_CHK;
                end
              end
              default: nxt_state = S_HUNT;
            endcase
          end
        end
      endcase
    end else if (state != S_HUNT && to_hit) begin
      nxt_state = S_HUNT;
      nxt_err   = 1'b1;
      nxt_code  = ERR_TO;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_HUNT;
      byte_cnt    <= '0;
      xor_acc     <= '0;
      hi_nib      <= '0;
      err_code    <= '0;
      frame_start <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= nxt_state;
      byte_cnt    <= nxt_cnt;
      xor_acc     <= nxt_xor;
      hi_nib      <= nxt_hi;
      err_code    <= nxt_code;
      frame_start <= nxt_start;
      frame_ok    <= nxt_ok;
      frame_err   <= nxt_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {hi_nib, info_judge};
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
